// File: rtl/arith_core_mc.sv
// -----------------------------------------------------------------------------
// arith_core_mc
//
// Multi-cycle integer core for a small subset of the MIPS instruction set.
// Each instruction is fetched over a simple request/acknowledge port, executed,
// and written back to a register file, one instruction at a time.
//
// Instruction fetch handshake:
//   inst_req is high for the whole of FETCH and inst_addr holds the PC steady
//   while it is high. The first cycle in FETCH where inst_ack is high is the
//   transfer cycle, and inst_data is captured on that edge. inst_ack is ignored
//   whenever inst_req is low.
//
// Ports:
//   clock      in   rising-edge clock, the only clock
//   reset      in   synchronous, active-high reset
//   inst_addr  out  [31:0] byte address of the requested instruction (PC)
//   inst_req   out  instruction fetch request
//   inst_ack   in   fetch acknowledge; inst_data is valid in the same cycle
//   inst_data  in   [31:0] instruction word (MIPS encoding)
//   except     out  sticky unrecognised-instruction flag
//   retire     out  one-cycle pulse per completed instruction
//   dbg_raddr  in   [log2(NREGS)-1:0] debug register index
//   dbg_rdata  out  [WIDTH-1:0] debug register value (combinational, r0 = 0)
//   dbg_state  out  [1:0] current FSM state (FETCH=0, EXEC=1, WB=2, EXCEPT=3)
// -----------------------------------------------------------------------------
module arith_core_mc #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              inst_addr,
    output logic                     inst_req,
    input  logic                     inst_ack,
    input  logic [31:0]              inst_data,
    output logic                     except,
    output logic                     retire,
    input  logic [$clog2(NREGS)-1:0] dbg_raddr,
    output logic [WIDTH-1:0]         dbg_rdata,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_WB     = 2'd2,
        S_EXCEPT = 2'd3
    } state_t;

    // Opcodes and R-type function codes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_result;
    logic [AW-1:0]    r_dest;
    logic [WIDTH-1:0] r_regs [NREGS];

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t           w_state_next;
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [AW-1:0]    w_rs;
    logic [AW-1:0]    w_rt;
    logic [AW-1:0]    w_rd;
    logic [15:0]      w_imm;
    logic [WIDTH-1:0] w_imm_sext;
    logic [WIDTH-1:0] w_imm_zext;
    logic [WIDTH-1:0] w_rs_val;
    logic [WIDTH-1:0] w_rt_val;
    logic [WIDTH-1:0] w_alu;
    logic [AW-1:0]    w_dest;
    logic             w_valid;

    // Register indices keep only the low log2(NREGS) bits of each 5-bit field.
    assign w_op       = r_ir[31:26];
    assign w_funct    = r_ir[5:0];
    assign w_rs       = r_ir[21 + AW - 1:21];
    assign w_rt       = r_ir[16 + AW - 1:16];
    assign w_rd       = r_ir[11 + AW - 1:11];
    assign w_imm      = r_ir[15:0];
    // Size casts: signed source sign-extends, unsigned source zero-extends.
    // This also covers WIDTH == 16 without a zero-length replication.
    assign w_imm_sext = WIDTH'($signed(w_imm));
    assign w_imm_zext = WIDTH'(w_imm);

    // Register 0 is never written, but decoding it explicitly keeps the
    // "reads as zero" guarantee independent of the write path.
    assign w_rs_val = (w_rs == '0) ? '0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 : r_regs[w_rt];

    // -------------------------------------------------------------------------
    // Decode and ALU: operates on the latched instruction during EXEC
    // -------------------------------------------------------------------------
    always_comb begin
        w_alu   = '0;
        w_dest  = w_rt;
        w_valid = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_dest = w_rd;
                case (w_funct)
                    FN_ADD: begin w_alu = w_rs_val + w_rt_val;    w_valid = 1'b1; end
                    FN_SUB: begin w_alu = w_rs_val - w_rt_val;    w_valid = 1'b1; end
                    FN_AND: begin w_alu = w_rs_val & w_rt_val;    w_valid = 1'b1; end
                    FN_OR:  begin w_alu = w_rs_val | w_rt_val;    w_valid = 1'b1; end
                    FN_XOR: begin w_alu = w_rs_val ^ w_rt_val;    w_valid = 1'b1; end
                    FN_NOR: begin w_alu = ~(w_rs_val | w_rt_val); w_valid = 1'b1; end
                    default: begin end
                endcase
            end
            // add/sub/addi wrap modulo 2^WIDTH; overflow is not trapped.
            OP_ADDI: begin w_alu = w_rs_val + w_imm_sext; w_valid = 1'b1; end
            OP_ANDI: begin w_alu = w_rs_val & w_imm_zext; w_valid = 1'b1; end
            OP_ORI:  begin w_alu = w_rs_val | w_imm_zext; w_valid = 1'b1; end
            OP_XORI: begin w_alu = w_rs_val ^ w_imm_zext; w_valid = 1'b1; end
            default: begin end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        inst_req     = 1'b0;
        retire       = 1'b0;
        except       = 1'b0;
        case (r_state)
            S_FETCH: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = w_valid ? S_WB : S_EXCEPT;
            end
            S_WB: begin
                retire       = 1'b1;
                w_state_next = S_FETCH;
            end
            S_EXCEPT: begin
                // Terminal until reset; the flag is sticky because the state is.
                except       = 1'b1;
                w_state_next = S_EXCEPT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, PC, instruction/result registers and register file
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_result <= '0;
            r_dest   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_FETCH: begin
                    if (inst_ack) begin
                        r_ir <= inst_data;
                    end
                end
                S_EXEC: begin
                    r_result <= w_alu;
                    r_dest   <= w_dest;
                end
                S_WB: begin
                    // Writes to r0 are dropped; the instruction still retires.
                    if (r_dest != '0) begin
                        r_regs[r_dest] <= r_result;
                    end
                    r_pc <= r_pc + 32'd4;
                end
                default: begin end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign inst_addr = r_pc;
    assign dbg_state = r_state;
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];

endmodule

// File: tb/tb_arith_core_mc.sv
// -----------------------------------------------------------------------------
// tb_arith_core_mc
//
// Directed bench for arith_core_mc. Two instances share the clock and reset:
// the default 32-bit / 32-register core and a 16-bit / 8-register core.
// "sel" chooses which core the fetch driver talks to and which core's outputs
// are observed; the unselected core sits in FETCH with no acknowledge.
// -----------------------------------------------------------------------------
module tb_arith_core_mc;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // DUT wiring
  // ---------------------------------------------------------------------------
  logic        sel;
  logic        ack;
  logic [31:0] data;

  logic [31:0] addr32, addr16;
  logic        req32, req16, exc32, exc16, ret32, ret16;
  logic [4:0]  dbg_raddr32;
  logic [2:0]  dbg_raddr16;
  logic [31:0] dbg_rdata32;
  logic [15:0] dbg_rdata16;
  logic [1:0]  st32, st16;

  arith_core_mc u_dut32 (
    .clock     (clock),
    .reset     (reset),
    .inst_addr (addr32),
    .inst_req  (req32),
    .inst_ack  (ack & ~sel),
    .inst_data (data),
    .except    (exc32),
    .retire    (ret32),
    .dbg_raddr (dbg_raddr32),
    .dbg_rdata (dbg_rdata32),
    .dbg_state (st32)
  );

  arith_core_mc #(.WIDTH(16), .NREGS(8)) u_dut16 (
    .clock     (clock),
    .reset     (reset),
    .inst_addr (addr16),
    .inst_req  (req16),
    .inst_ack  (ack & sel),
    .inst_data (data),
    .except    (exc16),
    .retire    (ret16),
    .dbg_raddr (dbg_raddr16),
    .dbg_rdata (dbg_rdata16),
    .dbg_state (st16)
  );

  logic [31:0] o_addr;
  logic        o_req, o_exc, o_ret;
  logic [1:0]  o_st;
  logic [31:0] o_reg;
  assign o_addr = sel ? addr16 : addr32;
  assign o_req  = sel ? req16  : req32;
  assign o_exc  = sel ? exc16  : exc32;
  assign o_ret  = sel ? ret16  : ret32;
  assign o_st   = sel ? st16   : st32;
  assign o_reg  = sel ? {16'h0000, dbg_rdata16} : dbg_rdata32;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_raddr32 = idx[4:0];
    dbg_raddr16 = idx[2:0];
    #1;
    check_eq(tag, {32'h0, o_reg}, {32'h0, exp});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one full instruction, acked after 'delay' wait cycles.
  // During EXEC and WB the ack line is held high with junk data to show it is
  // ignored outside FETCH.
  // ---------------------------------------------------------------------------
  task automatic run_inst(input string tag, input logic [31:0] instr, input int delay);
    for (int i = 0; i < delay; i++) begin
      ack = 1'b0;
      check_eq({tag, ".wait_req"},  {63'h0, o_req}, 64'd1);
      check_eq({tag, ".wait_addr"}, {32'h0, o_addr}, {32'h0, exp_pc});
      check_eq({tag, ".wait_ret"},  {63'h0, o_ret}, 64'd0);
      tick();
    end
    ack  = 1'b1;
    data = instr;
    check_eq({tag, ".ack_req"},  {63'h0, o_req}, 64'd1);
    check_eq({tag, ".ack_addr"}, {32'h0, o_addr}, {32'h0, exp_pc});
    tick();
    data = 32'hFFFF_FFFF;
    check_eq({tag, ".exec_state"}, {62'h0, o_st}, 64'd1);
    check_eq({tag, ".exec_req"},   {63'h0, o_req}, 64'd0);
    check_eq({tag, ".exec_ret"},   {63'h0, o_ret}, 64'd0);
    tick();
    check_eq({tag, ".wb_ret"},   {63'h0, o_ret}, 64'd1);
    check_eq({tag, ".wb_state"}, {62'h0, o_st}, 64'd2);
    tick();
    ack  = 1'b0;
    data = 32'h0;
    exp_pc = exp_pc + 32'd4;
    check_eq({tag, ".next_ret"},  {63'h0, o_ret}, 64'd0);
    check_eq({tag, ".next_req"},  {63'h0, o_req}, 64'd1);
    check_eq({tag, ".next_addr"}, {32'h0, o_addr}, {32'h0, exp_pc});
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    // Acknowledge with a real instruction during reset: must be ignored.
    ack  = 1'b1;
    data = 32'h2001_0005;
    tick();
    tick();
    reset = 1'b0;
    ack   = 1'b0;
    data  = 32'h0;
    exp_pc = 32'h0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table: instruction, destination, hand-computed result (32-bit core)
  // ---------------------------------------------------------------------------
  logic [31:0] tbl_instr [8] = '{
    32'h3065_00F0,  // andi r5,r3,0x00F0
    32'h3426_8000,  // ori  r6,r1,0x8000
    32'h3867_FFFF,  // xori r7,r3,0xFFFF
    32'h00C5_4025,  // or   r8,r6,r5
    32'h00E8_4826,  // xor  r9,r7,r8
    32'h0020_5027,  // nor  r10,r1,r0
    32'h00E3_5824,  // and  r11,r7,r3
    32'h00E7_6820   // add  r13,r7,r7 (overflows, wraps)
  };
  int          tbl_dest [8] = '{5, 6, 7, 8, 9, 10, 11, 13};
  logic [31:0] tbl_exp  [8] = '{
    32'h0000_00F0,
    32'h0000_8005,
    32'hFFFF_0001,
    32'h0000_80F5,
    32'hFFFF_80F4,
    32'hFFFF_FFFA,
    32'hFFFF_0000,
    32'hFFFE_0002
  };

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    sel = 1'b0;
    ack = 1'b0;
    data = 32'h0;
    reset = 1'b1;
    dbg_raddr32 = '0;
    dbg_raddr16 = '0;
    exp_pc = 32'h0;

    // Reset state
    apply_reset();
    check_eq("rst_req",    {63'h0, o_req}, 64'd1);
    check_eq("rst_addr",   {32'h0, o_addr}, 64'd0);
    check_eq("rst_except", {63'h0, o_exc}, 64'd0);
    check_eq("rst_retire", {63'h0, o_ret}, 64'd0);
    check_eq("rst_state",  {62'h0, o_st}, 64'd0);
    check_reg("rst_r1", 1, 32'h0);

    // addi r1,r0,5 acked immediately
    run_inst("addi_r1", 32'h2001_0005, 0);
    check_reg("r1", 1, 32'h0000_0005);

    // addi r2,r0,-7 then add r3,r1,r2
    run_inst("addi_r2", 32'h2002_FFF9, 0);
    check_reg("r2", 2, 32'hFFFF_FFF9);
    run_inst("add_r3", 32'h0022_1820, 0);
    check_reg("r3", 3, 32'hFFFF_FFFE);

    // Write to r0 is dropped but still retires
    run_inst("addi_r0", 32'h2000_0009, 0);
    check_reg("r0", 0, 32'h0);

    // Delayed ack: sub r4,r1,r2 after 4 wait cycles
    run_inst("sub_r4", 32'h0022_2022, 4);
    check_reg("r4", 4, 32'h0000_000C);

    // Logic ops, zero extension and add overflow
    for (int i = 0; i < 8; i++) begin
      run_inst($sformatf("tbl%0d", i), tbl_instr[i], i % 3);
      check_reg($sformatf("tbl%0d_reg", i), tbl_dest[i], tbl_exp[i]);
    end

    // Unrecognised opcode -> EXCEPT
    ack  = 1'b1;
    data = 32'hFC00_0000;
    tick();
    data = 32'h2001_0063;  // held on the bus, must never be fetched
    check_eq("exc_exec_flag", {63'h0, o_exc}, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("exc_flag",   {63'h0, o_exc}, 64'd1);
      check_eq("exc_req",    {63'h0, o_req}, 64'd0);
      check_eq("exc_retire", {63'h0, o_ret}, 64'd0);
      check_eq("exc_addr",   {32'h0, o_addr}, {32'h0, exp_pc});
      check_eq("exc_state",  {62'h0, o_st}, 64'd3);
      tick();
    end
    ack = 1'b0;
    check_reg("exc_r1", 1, 32'h0000_0005);
    check_reg("exc_r3", 3, 32'hFFFF_FFFE);

    // Unrecognised R-type funct also traps (after a reset)
    apply_reset();
    check_eq("exc_rst_flag", {63'h0, o_exc}, 64'd0);
    check_eq("exc_rst_addr", {32'h0, o_addr}, 64'd0);
    check_eq("exc_rst_req",  {63'h0, o_req}, 64'd1);
    check_reg("exc_rst_r3", 3, 32'h0);
    ack  = 1'b1;
    data = 32'h0022_1821;
    tick();
    ack = 1'b0;
    tick();
    check_eq("exc_funct_flag", {63'h0, o_exc}, 64'd1);

    // Reset while in WB must drop the pending write
    apply_reset();
    run_inst("pre_wb", 32'h2001_0005, 0);
    ack  = 1'b1;
    data = 32'h2004_0007;  // addi r4,r0,7
    tick();
    ack = 1'b0;
    tick();
    check_eq("abort_wb_ret", {63'h0, o_ret}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reg("abort_wb_r4", 4, 32'h0);
    check_eq("abort_wb_addr", {32'h0, o_addr}, 64'd0);

    // 16-bit / 8-register core
    sel = 1'b1;
    apply_reset();
    check_eq("w16_rst_addr", {32'h0, o_addr}, 64'd0);
    run_inst("w16_ori", 32'h3409_8000, 0);
    check_reg("w16_r1", 1, 32'h0000_8000);
    run_inst("w16_addi", 32'h2022_8000, 1);
    check_reg("w16_r2", 2, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
